// File: rtl/alu_pkg.sv
// Shared types for the ALU operand-select stage: source encodings, buffer states
// and the default-width operand entry.
package alu_pkg;

    localparam int unsigned ALU_DEF_WIDTH = 32;

    typedef enum logic [1:0] {
        SRC_A_PC   = 2'b00,
        SRC_A_REGA = 2'b01,
        SRC_A_ZERO = 2'b10,
        SRC_A_RSVD = 2'b11
    } alu_src_a_e;

    typedef enum logic [1:0] {
        SRC_B_REGB    = 2'b00,
        SRC_B_CONST   = 2'b01,
        SRC_B_IMM     = 2'b10,
        SRC_B_IMM_SHL = 2'b11
    } alu_src_b_e;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'b00,
        BUF_ONE   = 2'b01,
        BUF_FULL  = 2'b10
    } buf_state_e;

    // Operand entry as seen by an ALU built at the default datapath width.
    typedef struct packed {
        logic [ALU_DEF_WIDTH-1:0] a;
        logic [ALU_DEF_WIDTH-1:0] b;
        logic                     hit_a;
        logic                     hit_b;
    } alu_operand_t;

endpackage

// File: rtl/operand_fwd_sel.sv
// Priority forwarding match for one source register: the lowest-index valid
// source whose destination equals the specifier wins; register 0 never matches.
module operand_fwd_sel
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned NUM_FWD    = 2
) (
    input  logic [REG_ADDR_W-1:0]         rs_i,
    input  logic [WIDTH-1:0]              reg_data_i,
    input  logic [NUM_FWD-1:0]            fwd_valid_i,
    input  logic [NUM_FWD*REG_ADDR_W-1:0] fwd_addr_i,
    input  logic [NUM_FWD*WIDTH-1:0]      fwd_data_i,
    output logic [WIDTH-1:0]              data_c_o,
    output logic                          hit_c_o
);

    // Scan from oldest to youngest so the youngest matching source is applied last.
    always_comb begin
        data_c_o = reg_data_i;
        hit_c_o  = 1'b0;
        if (rs_i != '0) begin
            for (int k = int'(NUM_FWD) - 1; k >= 0; k--) begin
                if (fwd_valid_i[k] &&
                    (fwd_addr_i[k*REG_ADDR_W +: REG_ADDR_W] == rs_i)) begin
                    data_c_o = fwd_data_i[k*WIDTH +: WIDTH];
                    hit_c_o  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// Operand-select stage between register read and the ALU: source muxing,
// forwarding resolution at capture, and a 2-entry skid buffer toward the ALU.
module alu_operand_stage
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned NUM_FWD    = 2,
    parameter int unsigned IMM_SHIFT  = 2,
    parameter int unsigned CONST_B    = 1
) (
    input  logic                          i_Clk,
    input  logic                          i_Reset,
    input  logic                          i_Flush,
    input  logic                          i_Valid,
    output logic                          o_Ready,
    input  logic [1:0]                    i_AluSrcA,
    input  logic [1:0]                    i_AluSrcB,
    input  logic [WIDTH-1:0]              i_PC,
    input  logic [WIDTH-1:0]              i_RegA,
    input  logic [WIDTH-1:0]              i_RegB,
    input  logic [WIDTH-1:0]              i_Imm,
    input  logic [REG_ADDR_W-1:0]         i_RsA,
    input  logic [REG_ADDR_W-1:0]         i_RsB,
    input  logic [NUM_FWD-1:0]            i_FwdValid,
    input  logic [NUM_FWD*REG_ADDR_W-1:0] i_FwdAddr,
    input  logic [NUM_FWD*WIDTH-1:0]      i_FwdData,
    output logic                          o_Valid,
    input  logic                          i_Ready,
    output logic [WIDTH-1:0]              o_AluA,
    output logic [WIDTH-1:0]              o_AluB,
    output logic                          o_FwdHitA,
    output logic                          o_FwdHitB
);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             hit_a;
        logic             hit_b;
    } opnd_t;

    buf_state_e       state_q, state_d;
    opnd_t            out_q, out_d;
    opnd_t            skid_q, skid_d;
    logic             valid_q;
    logic             ready_q;

    opnd_t            cap_c;
    logic [WIDTH-1:0] fwd_a_data_c;
    logic [WIDTH-1:0] fwd_b_data_c;
    logic             fwd_a_hit_c;
    logic             fwd_b_hit_c;
    logic             in_fire_c;
    logic             out_fire_c;
    alu_src_a_e       src_a_c;
    alu_src_b_e       src_b_c;

    operand_fwd_sel #(
        .WIDTH      (WIDTH),
        .REG_ADDR_W (REG_ADDR_W),
        .NUM_FWD    (NUM_FWD)
    ) u_fwd_a (
        .rs_i        (i_RsA),
        .reg_data_i  (i_RegA),
        .fwd_valid_i (i_FwdValid),
        .fwd_addr_i  (i_FwdAddr),
        .fwd_data_i  (i_FwdData),
        .data_c_o    (fwd_a_data_c),
        .hit_c_o     (fwd_a_hit_c)
    );

    operand_fwd_sel #(
        .WIDTH      (WIDTH),
        .REG_ADDR_W (REG_ADDR_W),
        .NUM_FWD    (NUM_FWD)
    ) u_fwd_b (
        .rs_i        (i_RsB),
        .reg_data_i  (i_RegB),
        .fwd_valid_i (i_FwdValid),
        .fwd_addr_i  (i_FwdAddr),
        .fwd_data_i  (i_FwdData),
        .data_c_o    (fwd_b_data_c),
        .hit_c_o     (fwd_b_hit_c)
    );

    assign src_a_c = alu_src_a_e'(i_AluSrcA);
    assign src_b_c = alu_src_b_e'(i_AluSrcB);

    // Operand resolution for the entry captured this cycle; hits count only for register sources.
    always_comb begin
        cap_c = '0;
        unique case (src_a_c)
            SRC_A_PC:   cap_c.a = i_PC;
            SRC_A_REGA: begin
                cap_c.a     = fwd_a_data_c;
                cap_c.hit_a = fwd_a_hit_c;
            end
            SRC_A_ZERO: cap_c.a = '0;
            SRC_A_RSVD: cap_c.a = '0;
            default:    cap_c.a = '0;
        endcase
        unique case (src_b_c)
            SRC_B_REGB: begin
                cap_c.b     = fwd_b_data_c;
                cap_c.hit_b = fwd_b_hit_c;
            end
            SRC_B_CONST:   cap_c.b = WIDTH'(CONST_B);
            SRC_B_IMM:     cap_c.b = i_Imm;
            SRC_B_IMM_SHL: cap_c.b = i_Imm << IMM_SHIFT;
            default:       cap_c.b = '0;
        endcase
    end

    assign in_fire_c  = i_Valid && ready_q;
    assign out_fire_c = valid_q && i_Ready;

    // Skid-buffer next state; flush drops everything but leaves the data registers alone.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        unique case (state_q)
            BUF_EMPTY: begin
                if (in_fire_c) begin
                    state_d = BUF_ONE;
                    out_d   = cap_c;
                end
            end
            BUF_ONE: begin
                if (in_fire_c && out_fire_c) begin
                    out_d = cap_c;
                end else if (in_fire_c) begin
                    state_d = BUF_FULL;
                    skid_d  = cap_c;
                end else if (out_fire_c) begin
                    state_d = BUF_EMPTY;
                end
            end
            BUF_FULL: begin
                if (out_fire_c) begin
                    state_d = BUF_ONE;
                    out_d   = skid_q;
                end
            end
            default: state_d = BUF_EMPTY;
        endcase
        if (i_Flush) begin
            state_d = BUF_EMPTY;
            out_d   = out_q;
            skid_d  = skid_q;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q <= BUF_EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
            valid_q <= (state_d != BUF_EMPTY);
            ready_q <= (state_d != BUF_FULL);
        end
    end

    assign o_Valid   = valid_q;
    assign o_Ready   = ready_q;
    assign o_AluA    = out_q.a;
    assign o_AluB    = out_q.b;
    assign o_FwdHitA = out_q.hit_a;
    assign o_FwdHitB = out_q.hit_b;

endmodule
